// File: rtl/regfile_wr_decoder_seq_if.sv
// Host-side bus of the register-file write decoder: normal write request,
// sweep control and the registered write-enable outputs.
interface regfile_wr_decoder_seq_if #(
  parameter int SEL_W = 5
);
  localparam int NREG = 1 << SEL_W;

  logic             ctrl_writeEnable;
  logic [SEL_W-1:0] ctrl_writeReg;
  logic             sweep_start;
  logic             write_ready;
  logic             sweep_busy;
  logic             sweep_done;
  logic [NREG-1:0]  out_we;
  logic             out_clear;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output sweep_start,
    input  write_ready,
    input  sweep_busy,
    input  sweep_done,
    input  out_we,
    input  out_clear
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  sweep_start,
    output write_ready,
    output sweep_busy,
    output sweep_done,
    output out_we,
    output out_clear
  );
endinterface

// File: rtl/regfile_wr_decoder_seq.sv
// Registered one-hot write-enable decoder with a built-in clear sweep that
// walks every writable register once; index 0 can be write-protected.
module regfile_wr_decoder_seq #(
  parameter int SEL_W        = 5,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  regfile_wr_decoder_seq_if.slave  bus
);

  localparam int NREG = 1 << SEL_W;
  localparam logic [SEL_W-1:0] START_IDX = ZERO_PROTECT ? SEL_W'(1) : '0;
  localparam logic [SEL_W-1:0] LAST_IDX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [NREG-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t           r_state;
  logic [SEL_W-1:0] r_cnt;
  logic             r_last;
  logic [NREG-1:0]  r_we;
  logic             r_clear;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [SEL_W-1:0] w_cnt_nxt;
  logic             w_last_nxt;
  logic [NREG-1:0]  w_we_nxt;
  logic             w_clear_nxt;
  logic             w_wr_blocked;

  assign w_wr_blocked = ZERO_PROTECT && (bus.ctrl_writeReg == '0);

  // r_last marks that the final index has been issued; the next edge
  // leaves SWEEP so sweep_done follows the last clear by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_we_nxt    = '0;
    w_clear_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ctrl_writeEnable && !w_wr_blocked) begin
          w_we_nxt = onehot(bus.ctrl_writeReg);
        end else begin
          w_we_nxt = '0;
        end
        if (bus.sweep_start) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = START_IDX;
          w_last_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (r_last) begin
          w_state_nxt = ST_DONE;
          w_last_nxt  = 1'b0;
        end else begin
          w_we_nxt    = onehot(r_cnt);
          w_clear_nxt = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_cnt_nxt  = '0;
            w_last_nxt = 1'b1;
          end else begin
            w_cnt_nxt  = r_cnt + SEL_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_last_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; busy/done track the state they describe.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_we    <= '0;
      r_clear <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_we    <= w_we_nxt;
      r_clear <= w_clear_nxt;
      r_busy  <= (w_state_nxt == ST_SWEEP);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.write_ready = (r_state == ST_IDLE);
  assign bus.sweep_busy  = r_busy;
  assign bus.sweep_done  = r_done;
  assign bus.out_we      = r_we;
  assign bus.out_clear   = r_clear;

endmodule

// File: tb/tb_regfile_wr_decoder_seq.sv
// Randomized bench: three decoder configurations share one stimulus stream and
// are compared every cycle against a cycle-numbered sweep timeline model.
module tb_regfile_wr_decoder_seq;

  logic clock = 1'b0;
  logic ctrl_reset;
  always #5 clock = ~clock;

  regfile_wr_decoder_seq_if #(.SEL_W(5)) bus0 ();
  regfile_wr_decoder_seq_if #(.SEL_W(5)) bus1 ();
  regfile_wr_decoder_seq_if #(.SEL_W(1)) bus2 ();

  regfile_wr_decoder_seq #(.SEL_W(5), .ZERO_PROTECT(1'b1)) u_dut0 (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus0));
  regfile_wr_decoder_seq #(.SEL_W(5), .ZERO_PROTECT(1'b0)) u_dut1 (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus1));
  regfile_wr_decoder_seq #(.SEL_W(1), .ZERO_PROTECT(1'b1)) u_dut2 (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;
  int sel_w[3] = '{5, 5, 1};
  int zp[3]    = '{1, 0, 1};
  // -1 = idle; k >= 1 = k-th cycle after the edge that accepted sweep_start
  int phase[3] = '{-1, -1, -1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int d, input bit rst, input bit we, input int rg,
                            input bit st, output logic [31:0] e_we, output logic e_clr,
                            output logic e_busy, output logic e_done, output logic e_rdy);
    int nreg, len, s, np, k, r;
    nreg  = 1 << sel_w[d];
    s     = zp[d];
    len   = nreg - s;
    r     = rg % nreg;
    e_we  = 32'd0;
    e_clr = 1'b0;
    if (!rst) begin
      np = -1;
    end else if (phase[d] < 0) begin
      if (we && !(s == 1 && r == 0)) e_we = 32'd1 << r;
      np = st ? 1 : -1;
    end else begin
      k = phase[d] + 1;
      if (k >= 2 && k <= len + 1) begin
        e_we  = 32'd1 << (s + k - 2);
        e_clr = 1'b1;
      end
      np = (k <= len + 2) ? k : -1;
    end
    phase[d] = np;
    e_busy   = (np >= 1 && np <= len + 1);
    e_done   = (np == len + 2);
    e_rdy    = (np == -1);
  endtask

  task automatic step(input bit rst, input bit we, input int rg, input bit st);
    logic [31:0] ew[3];
    logic        ec[3], eb[3], ed[3], er[3];
    logic [31:0] gw[3];
    logic        gc[3], gb[3], gd[3], gr[3];
    @(negedge clock);
    ctrl_reset            = rst;
    bus0.ctrl_writeEnable = we;
    bus1.ctrl_writeEnable = we;
    bus2.ctrl_writeEnable = we;
    bus0.ctrl_writeReg    = rg[4:0];
    bus1.ctrl_writeReg    = rg[4:0];
    bus2.ctrl_writeReg    = rg[0];
    bus0.sweep_start      = st;
    bus1.sweep_start      = st;
    bus2.sweep_start      = st;
    for (int d = 0; d < 3; d++) model_edge(d, rst, we, rg, st, ew[d], ec[d], eb[d], ed[d], er[d]);
    @(posedge clock);
    #1;
    gw[0] = 32'(bus0.out_we);   gw[1] = 32'(bus1.out_we);   gw[2] = 32'(bus2.out_we);
    gc[0] = bus0.out_clear;     gc[1] = bus1.out_clear;     gc[2] = bus2.out_clear;
    gb[0] = bus0.sweep_busy;    gb[1] = bus1.sweep_busy;    gb[2] = bus2.sweep_busy;
    gd[0] = bus0.sweep_done;    gd[1] = bus1.sweep_done;    gd[2] = bus2.sweep_done;
    gr[0] = bus0.write_ready;   gr[1] = bus1.write_ready;   gr[2] = bus2.write_ready;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d out_we", d),      gw[d],        ew[d]);
      chk($sformatf("d%0d out_clear", d),   32'(gc[d]),   32'(ec[d]));
      chk($sformatf("d%0d sweep_busy", d),  32'(gb[d]),   32'(eb[d]));
      chk($sformatf("d%0d sweep_done", d),  32'(gd[d]),   32'(ed[d]));
      chk($sformatf("d%0d write_ready", d), 32'(gr[d]),   32'(er[d]));
    end
  endtask

  initial begin
    ctrl_reset            = 1'b0;
    bus0.ctrl_writeEnable = 1'b0; bus0.ctrl_writeReg = '0; bus0.sweep_start = 1'b0;
    bus1.ctrl_writeEnable = 1'b0; bus1.ctrl_writeReg = '0; bus1.sweep_start = 1'b0;
    bus2.ctrl_writeEnable = 1'b0; bus2.ctrl_writeReg = '0; bus2.sweep_start = 1'b0;

    repeat (2) step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)));

    for (int k = 0; k < 32; k++) step(1'b1, 1'b1, k, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);

    // full sweep with a dropped write at sweep cycle 5
    step(1'b1, 1'b0, 0, 1'b1);
    for (int i = 1; i <= 36; i++) step(1'b1, (i == 5), 7, 1'b0);

    // simultaneous start and write
    step(1'b1, 1'b1, 9, 1'b1);
    for (int i = 0; i < 36; i++)
      step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'b0);

    // reset in the middle of a sweep, then a fresh sweep
    step(1'b1, 1'b0, 0, 1'b1);
    for (int i = 1; i < 10; i++) step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 3, 1'b1);
    step(1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 36; i++) step(1'b1, 1'b0, 0, 1'b0);

    repeat (3000)
      step(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), 1'($urandom_range(0, 15) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
